// File: rtl/disp_pkg.sv
// disp_pkg: shared constants and types for the display scroll sequencer
package disp_pkg;
  localparam int WIDTH = 16;
  localparam int NDIG = 5;
  localparam int WIN = 3;
  localparam logic [1:0] POS_DEFAULT = 2'd1;
  localparam logic [1:0] POS_MAX = 2'd2;
  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;
  typedef logic [3:0] bcd_t;
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble, one add-3/shift step per step cycle
module bin2bcd_seq
  import disp_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   bin_in,
  output logic               done,
  output logic [4*NDIG-1:0]  bcd
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] bin;
  logic [CW-1:0] cnt;
  logic [4*NDIG-1:0] adj;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < NDIG; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      bcd <= '0;
      bin <= '0;
      cnt <= '0;
      done <= 1'b0;
    end else if (load) begin
      bcd <= '0;
      bin <= bin_in;
      cnt <= '0;
      done <= 1'b0;
    end else if (step && cnt != CW'(WIDTH)) begin
      {bcd, bin} <= {adj, bin} << 1;
      cnt <= cnt + 1'b1;
      done <= cnt == CW'(WIDTH - 1);
    end else
      done <= 1'b0;
endmodule

// File: rtl/disp_scroll_ctrl.sv
// disp_scroll_ctrl: captures the product, converts it to BCD and scrolls a 3-digit window
module disp_scroll_ctrl
  import disp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sl,
  input  logic             sr,
  input  logic             sign_in,
  input  logic [WIDTH-1:0] value,
  output logic [3:0]       win0,
  output logic [3:0]       win1,
  output logic [3:0]       win2,
  output logic             sign_out,
  output logic [1:0]       pos,
  output logic             busy,
  output logic             valid
);
  state_t state;
  logic start_q, sl_q, sr_q, start_rise, sl_rise, sr_rise, done, fin;
  logic [4*NDIG-1:0] bcd;
  logic [2:0] p;
  bcd_t dig [NDIG];
  bcd_t src [NDIG];
  assign start_rise = start & ~start_q;
  assign sl_rise = sl & ~sl_q;
  assign sr_rise = sr & ~sr_q;
  assign fin = state == CONV && done && !start_rise;
  // On the finishing cycle the window is taken straight from the fresh digits so it lands together with valid
  always_comb begin
    for (int i = 0; i < NDIG; i++) src[i] = fin ? bcd[4*(NDIG-1-i) +: 4] : dig[i];
    p = {1'b0, fin ? POS_DEFAULT : pos};
  end
  bin2bcd_seq u_conv (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (start_rise),
    .step   (state == CONV),
    .bin_in (value),
    .done   (done),
    .bcd    (bcd)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      {start_q, sl_q, sr_q} <= 3'b000;
      dig <= '{default: '0};
      {win0, win1, win2} <= '0;
      pos <= POS_DEFAULT;
      sign_out <= 1'b0;
      busy <= 1'b0;
      valid <= 1'b0;
    end else begin
      {start_q, sl_q, sr_q} <= {start, sl, sr};
      win0 <= src[p];
      win1 <= src[p + 3'd1];
      win2 <= src[p + 3'd2];
      if (start_rise) begin
        sign_out <= sign_in;
        busy <= 1'b1;
        valid <= 1'b0;
        state <= CONV;
      end else if (fin) begin
        dig <= src;
        pos <= POS_DEFAULT;
        busy <= 1'b0;
        valid <= 1'b1;
        state <= SHOW;
      end else if (state == SHOW && sl_rise != sr_rise)
        pos <= sl_rise ? (pos == POS_MAX ? pos : pos + 2'd1) : (pos == 2'd0 ? pos : pos - 2'd1);
    end
endmodule
